// File: rtl/load_store_unit.sv
// Load/store unit: lane alignment, req/gnt/rvalid data-memory handshake, load extension, exceptions; LSU_BUS_TIMEOUT_EN adds a bus watchdog.
// Result one cycle after rvalid (min 2 cycles after accept); upstream is stalled while an op is outstanding, gnt may be withheld indefinitely.
package lsu_pkg;
   typedef enum logic [3:0] {
      i_nop, i_alu, i_lb, i_lh, i_lw, i_lbu, i_lhu, s_sb, s_sh, s_sw
   } instr_type_e;

   typedef enum logic [2:0] {
      NO_EXCEPTION, LOAD_MISALIGNED, STORE_MISALIGNED, LOAD_ACCESS_FAULT, STORE_ACCESS_FAULT
   } exc_type_e;
endpackage

module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ex_valid_i,
   input  instr_type_e       instr_type_i,
   input  logic [XLEN-1:0]   addr_i,
   input  logic [XLEN-1:0]   wdata_i,
   input  logic              flush_i,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [XLEN-1:0]   dmem_addr_o,
   output logic [XLEN-1:0]   dmem_wdata_o,
   output logic [XLEN/8-1:0] dmem_be_o,
   input  logic              dmem_gnt_i,
   input  logic              dmem_rvalid_i,
   input  logic [XLEN-1:0]   dmem_rdata_i,
   input  logic              dmem_err_i,
   output logic              lsu_stall_o,
   output logic [XLEN-1:0]   rdata_o,
   output logic              rdata_valid_o,
   output exc_type_e         exc_type_o,
   output logic [XLEN-1:0]   exc_tval_o
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0]        state_q;
   logic              kill_q;
   logic [XLEN-1:0]   byte_addr_q;
   instr_type_e       type_q;
   logic              rdata_valid_q;
   exc_type_e         exc_q;
   logic [XLEN-1:0]   tval_q;
   logic [XLEN-1:0]   rdata_q;

   logic              is_load, is_store, misaligned;
   logic              mem_op_vld, accept, misaligned_exc;
   logic [XLEN/8-1:0] be_next;
   logic [XLEN-1:0]   wdata_next, load_ext;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic              resp_vld, resp_killed, timeout_hit, tmo_done;

   always_comb begin
      is_load    = instr_type_i inside {i_lb, i_lh, i_lw, i_lbu, i_lhu};
      is_store   = instr_type_i inside {s_sb, s_sh, s_sw};
      misaligned = 1'b0;
      be_next    = '0;
      wdata_next = '0;
      case (instr_type_i)
         i_lh, i_lhu: misaligned = addr_i[0];
         i_lw:        misaligned = |addr_i[1:0];
         s_sb: begin
            be_next    = 4'b0001 << addr_i[1:0];
            wdata_next = {4{wdata_i[7:0]}};
         end
         s_sh: begin
            misaligned = addr_i[0];
            be_next    = 4'b0011 << addr_i[1:0];
            wdata_next = {2{wdata_i[15:0]}};
         end
         s_sw: begin
            misaligned = |addr_i[1:0];
            be_next    = 4'hF;
            wdata_next = wdata_i;
         end
         default: ;
      endcase
   end

   // Acceptance and misalignment are only evaluated in IDLE; a flushed op raises nothing.
   assign mem_op_vld     = (state_q == ST_IDLE) && ex_valid_i && (is_load || is_store) && !flush_i && !rst_i;
   assign accept         = mem_op_vld && !misaligned;
   assign misaligned_exc = mem_op_vld && misaligned;

   assign byte_sel = dmem_rdata_i[{byte_addr_q[1:0], 3'b000} +: 8];
   assign half_sel = dmem_rdata_i[{byte_addr_q[1], 4'b0000} +: 16];

   always_comb begin
      load_ext = dmem_rdata_i;
      case (type_q)
         i_lb:    load_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         i_lbu:   load_ext = {{(XLEN-8){1'b0}}, byte_sel};
         i_lh:    load_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
         i_lhu:   load_ext = {{(XLEN-16){1'b0}}, half_sel};
         default: ;
      endcase
   end

   assign resp_vld    = dmem_rvalid_i && (((state_q == ST_REQ) && dmem_gnt_i) || (state_q == ST_WAIT));
   assign resp_killed = kill_q || flush_i;
   assign tmo_done    = timeout_hit && !resp_vld && !((state_q == ST_REQ) && dmem_gnt_i);

`ifdef LSU_BUS_TIMEOUT_EN
   logic [15:0] tmo_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                    tmo_cnt_q <= '0;
      else if (accept)              tmo_cnt_q <= '0;
      else if (state_q != ST_IDLE)  tmo_cnt_q <= tmo_cnt_q + 16'd1;
   end

   assign timeout_hit = (state_q != ST_IDLE) && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         kill_q        <= 1'b0;
         byte_addr_q   <= '0;
         type_q        <= i_nop;
         dmem_req_o    <= 1'b0;
         dmem_we_o     <= 1'b0;
         dmem_addr_o   <= '0;
         dmem_wdata_o  <= '0;
         dmem_be_o     <= '0;
         rdata_valid_q <= 1'b0;
         exc_q         <= NO_EXCEPTION;
         tval_q        <= '0;
         rdata_q       <= '0;
      end else begin
         rdata_valid_q <= 1'b0;
         exc_q         <= NO_EXCEPTION;
         tval_q        <= '0;
         case (state_q)
            ST_IDLE: if (accept) begin
               state_q      <= ST_REQ;
               kill_q       <= 1'b0;
               byte_addr_q  <= addr_i;
               type_q       <= instr_type_i;
               dmem_req_o   <= 1'b1;
               dmem_we_o    <= is_store;
               dmem_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
               dmem_wdata_o <= wdata_next;
               dmem_be_o    <= be_next;
            end
            ST_REQ: begin
               if (dmem_gnt_i) begin
                  dmem_req_o <= 1'b0;
                  kill_q     <= kill_q || flush_i;
                  state_q    <= dmem_rvalid_i ? ST_IDLE : ST_WAIT;
               end else if (flush_i || tmo_done) begin
                  dmem_req_o <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (dmem_rvalid_i || tmo_done) state_q <= ST_IDLE;
               else if (flush_i)              kill_q  <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
         // A killed op still drains the bus but reports nothing.
         if ((resp_vld || tmo_done) && !resp_killed) begin
            rdata_valid_q <= 1'b1;
            if (tmo_done || dmem_err_i) begin
               exc_q   <= dmem_we_o ? STORE_ACCESS_FAULT : LOAD_ACCESS_FAULT;
               tval_q  <= byte_addr_q;
               rdata_q <= '0;
            end else begin
               rdata_q <= dmem_we_o ? '0 : load_ext;
            end
         end
      end
   end

   assign lsu_stall_o   = (state_q != ST_IDLE) || accept;
   assign rdata_o       = rdata_q;
   assign rdata_valid_o = rdata_valid_q;
   assign exc_type_o    = misaligned_exc ? (is_store ? STORE_MISALIGNED : LOAD_MISALIGNED) : exc_q;
   assign exc_tval_o    = misaligned_exc ? addr_i : tval_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized + directed bench for load_store_unit against a byte-arithmetic reference model.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        ex_valid_i = 1'b0;
   instr_type_e instr_type_i = i_nop;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic        flush_i = 1'b0;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_gnt_i = 1'b0;
   logic        dmem_rvalid_i = 1'b0;
   logic [31:0] dmem_rdata_i = 32'hDEAD_BEEF;
   logic        dmem_err_i = 1'b0;
   logic        lsu_stall_o;
   logic [31:0] rdata_o;
   logic        rdata_valid_o;
   exc_type_e   exc_type_o;
   logic [31:0] exc_tval_o;

   int n_checks = 0;
   int n_errors = 0;

   load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .ex_valid_i(ex_valid_i), .instr_type_i(instr_type_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .dmem_err_i(dmem_err_i),
      .lsu_stall_o(lsu_stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
      .exc_type_o(exc_type_o), .exc_tval_o(exc_tval_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: access size, lanes and extension from plain arithmetic.
   function automatic int unsigned op_size(input instr_type_e t);
      case (t)
         i_lb, i_lbu, s_sb: return 1;
         i_lh, i_lhu, s_sh: return 2;
         i_lw, s_sw:        return 4;
         default:           return 0;
      endcase
   endfunction

   function automatic logic [31:0] model_be(input instr_type_e t, input logic [31:0] a);
      int unsigned ofs = a % 4;
      case (t)
         s_sb:    return 32'(1 << ofs);
         s_sh:    return 32'(3 << ofs);
         s_sw:    return 32'd15;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input instr_type_e t, input logic [31:0] w);
      case (t)
         s_sb:    return (w % 256) * 32'h0101_0101;
         s_sh:    return (w % 65536) * 32'h0001_0001;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input instr_type_e t, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] sh = d / (32'd1 << (8 * (a % 4)));
      logic [31:0] b  = sh % 256;
      logic [31:0] h  = sh % 65536;
      case (t)
         i_lb:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         i_lbu:   return b;
         i_lh:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         i_lhu:   return h;
         default: return d;
      endcase
   endfunction

   task automatic bus_idle();
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0; dmem_rdata_i = 32'hDEAD_BEEF;
   endtask

   task automatic drive_resp(input logic [31:0] rd, input logic err);
      dmem_rvalid_i = 1'b1; dmem_rdata_i = rd; dmem_err_i = err;
   endtask

   task automatic chk_reset_vals();
      chk("rst_req", 32'(dmem_req_o), 32'd0);
      chk("rst_we", 32'(dmem_we_o), 32'd0);
      chk("rst_addr", dmem_addr_o, 32'd0);
      chk("rst_wdata", dmem_wdata_o, 32'd0);
      chk("rst_be", 32'(dmem_be_o), 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_vld", 32'(rdata_valid_o), 32'd0);
      chk("rst_exc", 32'(exc_type_o), 32'(NO_EXCEPTION));
      chk("rst_tval", exc_tval_o, 32'd0);
      chk("rst_stall", 32'(lsu_stall_o), 32'd0);
   endtask

   // Starts with inputs being driven in some cycle; ends at the negedge of the last checked cycle.
   task automatic run_op(input instr_type_e t, input logic [31:0] a, input logic [31:0] w,
                         input int gnt_dly, input int rv_dly, input logic [31:0] rd, input logic err);
      int unsigned sz = op_size(t);
      bit store = (t == s_sb) || (t == s_sh) || (t == s_sw);
      ex_valid_i = 1'b1; instr_type_i = t; addr_i = a; wdata_i = w;
      #1;
      if (sz == 0 || (a % sz) != 32'd0) begin
         chk("noacc_stall", 32'(lsu_stall_o), 32'd0);
         if (sz != 0) begin
            chk("mis_exc", 32'(exc_type_o), store ? 32'(STORE_MISALIGNED) : 32'(LOAD_MISALIGNED));
            chk("mis_tval", exc_tval_o, a);
            chk("mis_req", 32'(dmem_req_o), 32'd0);
         end
         @(posedge clk_i); #1; ex_valid_i = 1'b0;
         @(negedge clk_i);
         chk("noacc_req", 32'(dmem_req_o), 32'd0);
         chk("noacc_exc", 32'(exc_type_o), 32'(NO_EXCEPTION));
         return;
      end
      chk("acc_stall", 32'(lsu_stall_o), 32'd1);
      @(posedge clk_i); #1; ex_valid_i = 1'b0;
      for (int c = 0; c <= gnt_dly; c++) begin
         if (c == gnt_dly) begin
            dmem_gnt_i = 1'b1;
            if (rv_dly == 0) drive_resp(rd, err);
         end
         @(negedge clk_i);
         chk("req", 32'(dmem_req_o), 32'd1);
         chk("addr", dmem_addr_o, a & ~32'd3);
         chk("we", 32'(dmem_we_o), 32'(store));
         chk("be", 32'(dmem_be_o), model_be(t, a));
         if (store) chk("wdata", dmem_wdata_o, model_wdata(t, w));
         chk("req_stall", 32'(lsu_stall_o), 32'd1);
         @(posedge clk_i); #1; bus_idle();
      end
      for (int c = 1; c <= rv_dly; c++) begin
         if (c == rv_dly) drive_resp(rd, err);
         @(negedge clk_i);
         chk("wait_req", 32'(dmem_req_o), 32'd0);
         chk("wait_stall", 32'(lsu_stall_o), 32'd1);
         @(posedge clk_i); #1; bus_idle();
      end
      @(negedge clk_i);
      chk("done_vld", 32'(rdata_valid_o), 32'd1);
      chk("done_stall", 32'(lsu_stall_o), 32'd0);
      if (err) begin
         chk("done_exc", 32'(exc_type_o), store ? 32'(STORE_ACCESS_FAULT) : 32'(LOAD_ACCESS_FAULT));
         chk("done_tval", exc_tval_o, a);
         chk("done_rdata", rdata_o, 32'd0);
      end else begin
         chk("done_exc", 32'(exc_type_o), 32'(NO_EXCEPTION));
         if (!store) chk("done_rdata", rdata_o, model_load(t, a, rd));
      end
   endtask

   task automatic idle_checks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i); #1;
         @(negedge clk_i);
         chk("idle_vld", 32'(rdata_valid_o), 32'd0);
         chk("idle_stall", 32'(lsu_stall_o), 32'd0);
      end
   endtask

   task automatic accept_lw(input logic [31:0] a);
      @(posedge clk_i); #1;
      ex_valid_i = 1'b1; instr_type_i = i_lw; addr_i = a;
      #1 chk("acc_lw_stall", 32'(lsu_stall_o), 32'd1);
      @(posedge clk_i); #1; ex_valid_i = 1'b0;
   endtask

   instr_type_e ops [10] = '{i_nop, i_alu, i_lb, i_lh, i_lw, i_lbu, i_lhu, s_sb, s_sh, s_sw};
   instr_type_e rt;
   logic [31:0] ra, rw, rd;
   int          gap;

   initial begin
      bus_idle();
      repeat (2) @(posedge clk_i);
      #1 chk_reset_vals();
      rst_i = 1'b0;
      @(negedge clk_i);
      chk_reset_vals();

      // Spec example: sign-extended byte load from the top lane.
      @(posedge clk_i); #1;
      run_op(i_lb, 32'h0000_1003, 32'd0, 0, 1, 32'h80FF_FF00, 1'b0);
      chk("tp_lb_rdata", rdata_o, 32'hFFFF_FF80);
      idle_checks(1);

      @(posedge clk_i); #1;
      run_op(s_sh, 32'h0000_2002, 32'h0000_ABCD, 0, 0, 32'd0, 1'b0);
      idle_checks(1);

      @(posedge clk_i); #1;
      run_op(i_lw, 32'h0000_3001, 32'd0, 0, 0, 32'd0, 1'b0);

      @(posedge clk_i); #1;
      run_op(i_lw, 32'h0000_4008, 32'd0, 3, 1, 32'h1234_5678, 1'b1);
      idle_checks(1);

      // Flush while waiting for the response: drained silently, stall held until rvalid.
      accept_lw(32'h0000_5000);
      dmem_gnt_i = 1'b1;
      @(posedge clk_i); #1; bus_idle(); flush_i = 1'b1;
      @(negedge clk_i); chk("fw_stall0", 32'(lsu_stall_o), 32'd1);
      @(posedge clk_i); #1; flush_i = 1'b0;
      @(negedge clk_i); chk("fw_stall1", 32'(lsu_stall_o), 32'd1);
      @(posedge clk_i); #1; drive_resp(32'h5555_AAAA, 1'b0);
      @(negedge clk_i); chk("fw_stall2", 32'(lsu_stall_o), 32'd1);
      @(posedge clk_i); #1; bus_idle();
      @(negedge clk_i);
      chk("fw_vld", 32'(rdata_valid_o), 32'd0);
      chk("fw_exc", 32'(exc_type_o), 32'(NO_EXCEPTION));
      chk("fw_stall3", 32'(lsu_stall_o), 32'd0);

      // Flush in REQ before gnt: request withdrawn; a stray gnt/rvalid afterwards is ignored.
      accept_lw(32'h0000_6000);
      flush_i = 1'b1;
      @(negedge clk_i); chk("fr_req0", 32'(dmem_req_o), 32'd1);
      @(posedge clk_i); #1; flush_i = 1'b0; dmem_gnt_i = 1'b1; drive_resp(32'h0000_0001, 1'b1);
      @(negedge clk_i);
      chk("fr_req1", 32'(dmem_req_o), 32'd0);
      chk("fr_stall", 32'(lsu_stall_o), 32'd0);
      @(posedge clk_i); #1; bus_idle();
      @(negedge clk_i);
      chk("fr_vld", 32'(rdata_valid_o), 32'd0);
      chk("fr_exc", 32'(exc_type_o), 32'(NO_EXCEPTION));

      // Flush in IDLE blocks acceptance.
      @(posedge clk_i); #1;
      ex_valid_i = 1'b1; instr_type_i = i_lw; addr_i = 32'h0000_7000; flush_i = 1'b1;
      #1 chk("fi_stall", 32'(lsu_stall_o), 32'd0);
      @(posedge clk_i); #1; ex_valid_i = 1'b0; flush_i = 1'b0;
      @(negedge clk_i); chk("fi_req", 32'(dmem_req_o), 32'd0);

      // Reset mid-transaction, then a late response in IDLE.
      @(posedge clk_i); #1;
      ex_valid_i = 1'b1; instr_type_i = s_sw; addr_i = 32'h0000_8004; wdata_i = 32'hCAFE_F00D;
      @(posedge clk_i); #1; ex_valid_i = 1'b0;
      @(negedge clk_i); chk("rr_req", 32'(dmem_req_o), 32'd1);
      #1 rst_i = 1'b1;
      #1 chk_reset_vals();
      @(posedge clk_i); #1; rst_i = 1'b0; dmem_gnt_i = 1'b1; drive_resp(32'h0BAD_0BAD, 1'b0);
      @(negedge clk_i); chk("rr_vld0", 32'(rdata_valid_o), 32'd0);
      @(posedge clk_i); #1; bus_idle();
      @(negedge clk_i);
      chk("rr_vld1", 32'(rdata_valid_o), 32'd0);
      chk("rr_stall", 32'(lsu_stall_o), 32'd0);

      // Randomized ops with random bus latency, errors and back-to-back issue.
      for (int n = 0; n < 80; n++) begin
         rt  = ops[$urandom_range(0, 9)];
         ra  = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
         rw  = $urandom;
         rd  = $urandom;
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            idle_checks(gap - 1);
            @(posedge clk_i); #1;
         end
         run_op(rt, ra, rw, $urandom_range(0, 3), $urandom_range(0, 3), rd, ($urandom_range(0, 7) == 0));
      end

      // Bus never grants: watchdog fault if built in, otherwise an indefinite stall.
      idle_checks(1);
      accept_lw(32'h0000_9000);
`ifdef LSU_BUS_TIMEOUT_EN
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk_i); chk("tmo_stall", 32'(lsu_stall_o), 32'd1);
         @(posedge clk_i); #1;
      end
      @(negedge clk_i);
      chk("tmo_exc", 32'(exc_type_o), 32'(LOAD_ACCESS_FAULT));
      chk("tmo_tval", exc_tval_o, 32'h0000_9000);
      chk("tmo_rdata", rdata_o, 32'd0);
      chk("tmo_req", 32'(dmem_req_o), 32'd0);
      chk("tmo_stall_end", 32'(lsu_stall_o), 32'd0);
`else
      for (int c = 0; c < 100; c++) begin
         @(negedge clk_i);
         chk("hang_stall", 32'(lsu_stall_o), 32'd1);
         chk("hang_req", 32'(dmem_req_o), 32'd1);
         @(posedge clk_i); #1;
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the execute stage. It takes the effective address and store data produced by execute, performs byte-lane alignment, and runs a req/gnt/rvalid handshake with the data-memory port. It returns sign- or zero-extended load data and reports misaligned and access-fault exceptions. It stalls the pipeline for the duration of each bus transaction.

## Interface
- XLEN, 32, data/address width; only 32 is supported, so byte-enable width is XLEN/8 = 4.
- TIMEOUT_CYCLES, 255, bus watchdog limit; used only when `LSU_BUS_TIMEOUT_EN` is defined.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ex_valid_i  in  1  execute presents a valid instruction this cycle.
- instr_type_i  in  instr_type_e  decoded type; memory ops are i_lb, i_lh, i_lw, i_lbu, i_lhu, s_sb, s_sh, s_sw.
- addr_i  in  XLEN  effective address (execute ALU result).
- wdata_i  in  XLEN  store data (forwarded rs2).
- flush_i  in  1  kill the current or accepted operation.
- dmem_req_o  out  1  request, registered.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  XLEN  word-aligned address ({addr[31:2], 2'b00}).
- dmem_wdata_o  out  XLEN  lane-replicated store data.
- dmem_be_o  out  4  byte enables.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  response valid.
- dmem_rdata_i  in  XLEN  response data.
- dmem_err_i  in  1  bus error; qualified by dmem_rvalid_i.
- lsu_stall_o  out  1  hold upstream stages.
- rdata_o  out  XLEN  extended load result, registered.
- rdata_valid_o  out  1  one-cycle completion pulse (loads and stores).
- exc_type_o  out  exc_type_e  NO_EXCEPTION, LOAD_MISALIGNED, STORE_MISALIGNED, LOAD_ACCESS_FAULT or STORE_ACCESS_FAULT.
- exc_tval_o  out  XLEN  faulting byte address.

## Operation

**FSM states**
- IDLE → REQ: accept when ex_valid_i && memory op && aligned && !flush_i. Register address, type, lanes, data and we.
- REQ: dmem_req_o = 1, with addr, we, be and wdata held stable.
  - gnt && rvalid in the same cycle → IDLE.
  - gnt alone → WAIT.
- WAIT: rvalid → IDLE.

**Alignment**
- Misaligned: lh, lhu, sh with addr[0] = 1; lw, sw with addr[1:0] ≠ 0.
- A misaligned access is detected combinationally in IDLE. exc_type_o and exc_tval_o = addr_i in the same cycle. No request is issued and there is no stall.

**Store lanes**
- sb: be = 4'b0001 << addr[1:0], byte replicated ×4.
- sh: be = 4'b0011 << addr[1:0], halfword replicated ×2.
- sw: be = 4'hF.

**Load extraction**
- Select the byte or halfword at addr[1:0]×8.
- lb and lh sign-extend; lbu and lhu zero-extend; lw passes through.

**Completion** (rvalid in REQ/WAIT, not killed)
- Next cycle: rdata_valid_o = 1 for one cycle and rdata_o is updated.
- If dmem_err_i: LOAD_ACCESS_FAULT or STORE_ACCESS_FAULT, tval = latched address, rdata_o = 0.

**Stall**
- lsu_stall_o = (state ≠ IDLE) || (IDLE && accepting).

**Flush**
- In IDLE: blocks acceptance.
- In REQ without gnt the same cycle: immediate return to IDLE and dmem_req_o drops.
- Otherwise: set kill flag. The transaction completes on the bus, but rdata_valid_o and the exception are suppressed. The stall is held until the response arrives.

**Reset**
- Applies at any time, including mid-transaction: state → IDLE and the kill flag clears.
- A late rvalid arriving in IDLE is ignored.
- Reset values: dmem_req_o = 0, dmem_we_o = 0, dmem_addr_o = 0, dmem_wdata_o = 0, dmem_be_o = 0, rdata_o = 0, rdata_valid_o = 0, exc_type_o = NO_EXCEPTION, exc_tval_o = 0, lsu_stall_o = 0.

## Timing
- Minimum load/store latency, with gnt at T1 and rvalid at T2:
  - T0: accept; stall = 1.
  - T1: REQ.
  - T2: WAIT.
  - T3: IDLE with rdata_valid_o = 1 and stall = 0.
- With gnt and rvalid both at T1, completion is at T2.
- Back-to-back: a new op may be accepted in the same cycle that rdata_valid_o pulses.
- Outputs are stable in REQ until gnt; the bus may hold gnt low indefinitely.
- rvalid in IDLE, or gnt outside REQ, is ignored.

## Configuration
- `LSU_BUS_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter clears on acceptance and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES: state → IDLE, dmem_req_o = 0, a one-cycle access-fault pulse with the latched tval, rdata_o = 0.
  - A flushed op times out silently.
- Not defined: no counter; REQ and WAIT wait forever.

## Test plan
- lb at addr 0x1003, rdata 0x80FF_FF00, gnt at T1, rvalid at T2 → be = 0x0, addr 0x1000, T3: rdata_o = 0xFFFF_FF80, rdata_valid_o = 1, stall low at T3.
- sh data 0x0000_ABCD at 0x2002 → dmem_be_o = 4'b1100, dmem_wdata_o = 0xABCD_ABCD, dmem_we_o = 1, completion pulse with NO_EXCEPTION.
- lw at 0x3001 → same cycle: LOAD_MISALIGNED, tval = 0x3001, dmem_req_o stays 0, lsu_stall_o = 0.
- lw with gnt delayed 3 cycles, then rvalid and dmem_err_i → addr, be and we stable throughout REQ; completion: LOAD_ACCESS_FAULT, tval = address, rdata_o = 0.
- flush_i in WAIT, then rvalid → no rdata_valid_o and no exception, stall held until rvalid; rst_i pulsed in REQ → req low immediately, all outputs at reset values.
- `LSU_BUS_TIMEOUT_EN` with TIMEOUT_CYCLES = 4 and gnt never asserted → fault pulse 4 cycles after entering REQ, then IDLE; without the macro, the stall persists for 100 cycles.
